// File: rtl/seg_share_sched_pkg.sv
// Shared constants and the hex-digit segment table for the 7-segment scheduler.
// Segment bytes are active-low {a,b,c,d,e,f,g,dp}.
package seg_share_sched_pkg;

    localparam int NUM_W = 8;
    localparam int SEG_W = 16;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_share_sched_if.sv
// Requester/display bundle between the producer FSMs and the shared scheduler.
interface seg_share_sched_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    import seg_share_sched_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_en;
    logic [NUM_W*N_REQ-1:0] req_num;
    logic [SEG_W*N_REQ-1:0] seg_out;
    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic                   busy;

    modport master (
        output req_valid, req_en, req_num,
        input  req_ready, seg_out, grant_vld, grant_idx, busy
    );

    modport slave (
        input  req_valid, req_en, req_num,
        output req_ready, seg_out, grant_vld, grant_idx, busy
    );
endinterface

// File: rtl/seg_share_sched_num2seg.sv
// Two-digit hex to 7-segment decoder; en=0 blanks both digits.
module seg_share_sched_num2seg
    import seg_share_sched_pkg::*;
(
    input  logic             en_i,
    input  logic [NUM_W-1:0] num_i,
    output logic [SEG_W-1:0] seg_o
);
    assign seg_o = en_i ? {seg_digit(num_i[7:4]), seg_digit(num_i[3:0])}
                        : {SEG_BLANK, SEG_BLANK};
endmodule

// File: rtl/seg_share_sched.sv
// Round-robin scheduler sharing one num2seg decoder across N_REQ display slots;
// one pending slot is decoded per cycle and its segment word is held.
module seg_share_sched
    import seg_share_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    seg_share_sched_if.slave bus
);
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] en_q, en_d;
    logic [NUM_W-1:0] num_q [N_REQ];
    logic [NUM_W-1:0] num_d [N_REQ];
    logic [SEG_W-1:0] seg_q [N_REQ];
    logic [SEG_W-1:0] seg_d [N_REQ];
    logic [IDX_W-1:0] rr_last_q, rr_last_d;

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [SEG_W-1:0] dec_seg;

    // Scan starts just after the last served slot so every pending slot is
    // reached within N_REQ cycles.
    always_comb begin
        int j;
        logic [IDX_W-1:0] cand;
        j         = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(rr_last_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            cand = IDX_W'(j);
            if (!grant_vld && pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    seg_share_sched_num2seg u_dec (
        .en_i  (grant_vld & en_q[grant_idx]),
        .num_i (num_q[grant_idx]),
        .seg_o (dec_seg)
    );

    // A granted slot is pending, so it cannot accept on the edge it is served.
    always_comb begin
        pending_d = pending_q;
        en_d      = en_q;
        num_d     = num_q;
        seg_d     = seg_q;
        rr_last_d = rr_last_q;
        if (grant_vld) begin
            pending_d[grant_idx] = 1'b0;
            seg_d[grant_idx]     = dec_seg;
            rr_last_d            = grant_idx;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                en_d[i]      = bus.req_en[i];
                num_d[i]     = bus.req_num[NUM_W*i +: NUM_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            en_q      <= '0;
            rr_last_q <= IDX_W'(N_REQ - 1);
            for (int i = 0; i < N_REQ; i++) begin
                num_q[i] <= '0;
                seg_q[i] <= {SEG_BLANK, SEG_BLANK};
            end
        end else begin
            pending_q <= pending_d;
            en_q      <= en_d;
            rr_last_q <= rr_last_d;
            num_q     <= num_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.req_ready = ~pending_q;
    assign bus.busy      = |pending_q;
    assign bus.grant_vld = grant_vld;
    assign bus.grant_idx = grant_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_seg
        assign bus.seg_out[SEG_W*gi +: SEG_W] = seg_q[gi];
    end
endmodule

// File: tb/tb_seg_share_sched.sv
// Self-checking bench: directed tables, corner sequences and a randomized run
// against a slot-level reference model.
module tb_seg_share_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_share_sched_if #(.N_REQ(N), .IDX_W(2)) bus ();

    seg_share_sched #(.N_REQ(N), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_pend [N];
    bit          m_en   [N];
    logic [7:0]  m_num  [N];
    logic [15:0] m_seg  [N];
    int          m_rr;

    // Lit segments per hex digit; a is the byte MSB, dp the LSB, lit = 0.
    string lit_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] digit_code(input int d);
        logic [7:0] b;
        string s;
        b = 8'hFF;
        s = lit_tbl[d];
        for (int i = 0; i < s.len(); i++) b[7 - (s[i] - "a")] = 1'b0;
        return b;
    endfunction

    function automatic logic [15:0] ref_code(input bit en, input logic [7:0] num);
        if (!en) return 16'hFFFF;
        return {digit_code(int'(num[7:4])), digit_code(int'(num[3:0]))};
    endfunction

    function automatic int m_grant();
        for (int k = 1; k <= N; k++) begin
            if (m_pend[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_num[i] = 8'h00; m_seg[i] = 16'hFFFF;
        end
        m_rr = N - 1;
    endtask

    task automatic m_edge();
        bit acc [N];
        int g;
        for (int i = 0; i < N; i++) acc[i] = bus.req_valid[i] && !m_pend[i];
        g = m_grant();
        if (g >= 0) begin
            m_seg[g]  = ref_code(m_en[g], m_num[g]);
            m_pend[g] = 0;
            m_rr      = g;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                m_pend[i] = 1;
                m_en[i]   = bus.req_en[i];
                m_num[i]  = bus.req_num[8*i +: 8];
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [3:0]  rdy;
        logic [63:0] segs;
        int g;
        g = m_grant();
        for (int i = 0; i < N; i++) begin
            rdy[i] = !m_pend[i];
            segs[16*i +: 16] = m_seg[i];
        end
        chk({tag, ".busy"}, 64'(bus.busy), 64'(~&rdy));
        chk({tag, ".ready"}, 64'(bus.req_ready), 64'(rdy));
        chk({tag, ".gvld"}, 64'(bus.grant_vld), 64'(g >= 0));
        if (g >= 0) chk({tag, ".gidx"}, 64'(bus.grant_idx), 64'(g));
        chk({tag, ".seg"}, bus.seg_out, segs);
    endtask

    // Called just after a negedge with inputs set; returns after the next negedge.
    task automatic cyc(input string tag);
        check_state(tag);
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_en    = '0;
        bus.req_num   = '0;
    endtask

    task automatic post(input int slot, input bit en, input logic [7:0] num);
        bus.req_valid[slot]      = 1'b1;
        bus.req_en[slot]         = en;
        bus.req_num[8*slot +: 8] = num;
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, ".rst_seg"}, bus.seg_out, {4{16'hFFFF}});
        chk({tag, ".rst_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, ".rst_ready"}, 64'(bus.req_ready), 64'hF);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int          slot;
        bit          en;
        logic [7:0]  num;
        logic [15:0] exp;
    } dec_vec_t;

    dec_vec_t vecs [7];

    initial begin
        logic [7:0] nums [4];
        vecs[0] = '{0, 1'b1, 8'h12, 16'h9F25};
        vecs[1] = '{1, 1'b0, 8'h3A, 16'hFFFF};
        vecs[2] = '{2, 1'b1, 8'h0F, 16'h0371};
        vecs[3] = '{3, 1'b1, 8'hA5, 16'h1149};
        vecs[4] = '{0, 1'b1, 8'h80, 16'h0103};
        vecs[5] = '{1, 1'b1, 8'h99, 16'h0909};
        vecs[6] = '{2, 1'b0, 8'h77, 16'hFFFF};

        idle_inputs();
        m_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        rst = 1'b0;

        // Slot 0 handshake: ready low for exactly one cycle, then decoded
        post(0, 1'b1, 8'h12);
        chk("t2.ready_before", 64'(bus.req_ready[0]), 64'(1));
        cyc("t2a");
        idle_inputs();
        chk("t2.ready_low", 64'(bus.req_ready[0]), 64'(0));
        cyc("t2b");
        chk("t2.ready_back", 64'(bus.req_ready[0]), 64'(1));
        chk("t2.seg0", 64'(bus.seg_out[15:0]), 64'h9F25);

        // Slot 1 blank request leaves other slots alone
        post(1, 1'b0, 8'h3A);
        cyc("t3a");
        idle_inputs();
        cyc("t3b");
        chk("t3.seg1", 64'(bus.seg_out[31:16]), 64'hFFFF);
        chk("t3.seg0", 64'(bus.seg_out[15:0]), 64'h9F25);

        // Decode table, one uncontended request at a time
        foreach (vecs[v]) begin
            post(vecs[v].slot, vecs[v].en, vecs[v].num);
            cyc("tbl_acc");
            idle_inputs();
            cyc("tbl_srv");
            chk($sformatf("tbl%0d.seg", v), 64'(bus.seg_out[16*vecs[v].slot +: 16]),
                64'(vecs[v].exp));
        end

        // All four on one edge: served 0,1,2,3 in order
        mid_reset("t4pre");
        nums = '{8'h0F, 8'hA5, 8'h80, 8'h99};
        for (int i = 0; i < N; i++) post(i, 1'b1, nums[i]);
        cyc("t4acc");
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t4.gidx%0d", k), 64'(bus.grant_idx), 64'(k));
            cyc("t4srv");
        end
        chk("t4.final", bus.seg_out, {16'h0909, 16'h0103, 16'h1149, 16'h0371});

        // Slots 0 and 2 re-request whenever ready: grants must alternate
        for (int n = 0; n < 9; n++) begin
            idle_inputs();
            if (bus.req_ready[0]) post(0, 1'b1, 8'(n));
            if (bus.req_ready[2]) post(2, 1'b1, 8'(8'h40 + n));
            if (n > 0) begin
                chk($sformatf("t5.gvld%0d", n), 64'(bus.grant_vld), 64'(1));
                chk($sformatf("t5.gidx%0d", n), 64'(bus.grant_idx), 64'((n % 2 == 1) ? 0 : 2));
            end
            cyc("t5");
        end
        idle_inputs();
        repeat (2) cyc("t5drain");

        // Reset after first grant drops everything; slot 3 then served at once
        for (int i = 0; i < N; i++) post(i, 1'b1, 8'(8'h11 * i));
        cyc("t6acc");
        idle_inputs();
        cyc("t6first");
        mid_reset("t6");
        post(3, 1'b1, 8'h4C);
        cyc("t6req");
        idle_inputs();
        chk("t6.gvld", 64'(bus.grant_vld), 64'(1));
        chk("t6.gidx", 64'(bus.grant_idx), 64'(3));
        cyc("t6srv");
        chk("t6.seg3", 64'(bus.seg_out[63:48]), 64'h9963);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.req_valid = 4'($urandom);
            bus.req_en    = 4'($urandom) | 4'($urandom);
            bus.req_num   = 32'($urandom);
            if (n == 200) begin
                check_state("rnd_pre_rst");
                mid_reset("rnd");
            end
            cyc("rnd");
        end
        idle_inputs();
        repeat (N + 1) cyc("rnd_drain");
        chk("end.busy", 64'(bus.busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
